// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM states and the
// iteration-counter width helper.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore the partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // One extra bit above the remainder acts as the borrow of the trial subtract.
  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign o_qbit  = ~w_diff[WIDTH+1];
  assign o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divider_param.sv
// Signed/unsigned restoring divider, one quotient bit per cycle; latency WIDTH+1 edges
// (divide-by-zero: 1). Start is only taken while Ready is high; no queueing.
module seq_divider_param
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_ready;
  logic             r_done;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_src;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_dvd_neg = i_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_signed & i_divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_abs = w_dvs_neg ? -i_divisor : i_divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_dvd_msb(r_dvd[WIDTH-1]),
    .i_dvs    (r_dvs),
    .o_rem    (w_rem_nxt),
    .o_qbit   (w_qbit)
  );

  // On divide-by-zero r_dvd still holds |dividend|; re-applying the dividend sign
  // reproduces the original operand bit-exactly, including the most negative value.
  assign w_quot_fix = r_div0 ? '1 : (r_neg_q ? -r_dvd : r_dvd);
  assign w_rem_src  = r_div0 ? r_dvd : r_rem[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -w_rem_src : w_rem_src;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = FIX;
        end
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_done  <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_div0  <= (i_divisor == '0);
            r_dvd   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_rem   <= '0;
            r_cnt   <= CNT_LOAD;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_quot <= w_quot_fix;
          r_remd <= w_rem_fix;
          r_dbz  <= r_div0;
        end
        default: ;
      endcase
    end
  end

  assign o_quotient    = r_quot;
  assign o_remainder   = r_remd;
  assign o_ready       = r_ready;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;

endmodule
